// File: rtl/usat_integ_pkg.sv
// Shared definitions for the unsigned integrate-and-dump accumulator.
//   ISZ      default input sample width
//   OSZ      default accumulator/output width
//   CSZ      default block-length counter width
//   OSZ_ONES all-ones value at the default output width (saturation level)
//   widths_ok() elaboration-time width sanity check (osz must exceed isz)
package usat_integ_pkg;

  localparam int ISZ = 12;
  localparam int OSZ = 16;
  localparam int CSZ = 5;

  localparam logic [OSZ-1:0] OSZ_ONES = {OSZ{1'b1}};

  function automatic bit widths_ok(input int i_w, input int o_w);
    return o_w > i_w;
  endfunction

endpackage

// File: rtl/usat_add.sv
// Combinational unsigned saturating adder.
//   a   [osz-1:0]  running sum
//   b   [isz-1:0]  unsigned sample, zero-extended before the add
//   sum [osz-1:0]  a + b, clamped to all ones on overflow
//   ovf            the unclamped sum exceeded the osz-bit range
module usat_add
  import usat_integ_pkg::*;
#(
  parameter int isz = ISZ,
  parameter int osz = OSZ
) (
  input  logic [osz-1:0] a,
  input  logic [isz-1:0] b,
  output logic [osz-1:0] sum,
  output logic           ovf
);

  // One extra bit holds the carry so overflow is exact.
  logic [osz:0] full;

  assign full = {1'b0, a} + (osz+1)'(b);
  assign ovf  = full[osz];
  assign sum  = ovf ? {osz{1'b1}} : full[osz-1:0];

endmodule

// File: rtl/usat_integ.sv
// Unsigned integrate-and-dump accumulator.
// Sums len+1 valid samples into a wide accumulator, then dumps one clamped
// result with a one-cycle valid strobe.
//   clk, reset    clock, asynchronous active-high reset
//   ena, in       sample qualifier and unsigned sample
//   len           block length minus 1, captured at the start of each block
//   out, sat      dumped sum and block-saturated flag, held between dumps
//   valid         one-cycle dump strobe
//   clr           (only with SAT_INTEG_CLR_EN) synchronous block abort
//
// state  | meaning (implicit in cnt)
// IDLE   | cnt = 0, next ena sample latches len and starts a block
// ACCUM  | 0 < cnt <= len_q, samples being summed
// DUMP   | ena sample with cnt == length: out/sat/valid load, block clears
module usat_integ
  import usat_integ_pkg::*;
#(
  parameter int isz = ISZ,
  parameter int osz = OSZ,
  parameter int csz = CSZ
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ena,
  input  logic [isz-1:0] in,
  input  logic [csz-1:0] len,
`ifdef SAT_INTEG_CLR_EN
  input  logic           clr,
`endif
  output logic [osz-1:0] out,
  output logic           valid,
  output logic           sat
);

  if (!widths_ok(isz, osz)) begin : g_width_check
    $error("usat_integ: osz must be greater than isz");
  end

  logic [osz-1:0] acc;
  logic [osz-1:0] sum;
  logic           ovf;
  logic           sticky;
  logic [csz-1:0] cnt;
  logic [csz-1:0] len_q;
  logic [csz-1:0] len_eff;
  logic           last;

  usat_add #(.isz(isz), .osz(osz)) u_add (
    .a   (acc),
    .b   (in),
    .sum (sum),
    .ovf (ovf)
  );

  // The first sample of a block uses the live len, since it is being latched
  // on that same edge; later samples use the latched copy.
  assign len_eff = (cnt == '0) ? len : len_q;
  assign last    = (cnt == len_eff);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      cnt    <= '0;
      sticky <= 1'b0;
      len_q  <= '0;
      out    <= '0;
      valid  <= 1'b0;
      sat    <= 1'b0;
    end else begin
      valid <= 1'b0;
`ifdef SAT_INTEG_CLR_EN
      if (clr) begin
        acc    <= '0;
        cnt    <= '0;
        sticky <= 1'b0;
      end else
`endif
      if (ena) begin
        if (cnt == '0) len_q <= len;
        if (last) begin
          out    <= sum;
          sat    <= sticky | ovf;
          valid  <= 1'b1;
          acc    <= '0;
          cnt    <= '0;
          sticky <= 1'b0;
        end else begin
          acc    <= sum;
          cnt    <= cnt + csz'(1);
          sticky <= sticky | ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_usat_integ.sv
// Self-checking bench for usat_integ: a table of per-cycle vectors plus
// hand-written sequences for saturation, asynchronous reset and clr.
module tb_usat_integ;
  import usat_integ_pkg::*;

  logic           clk = 1'b0;
  logic           reset;
  logic           ena;
  logic [ISZ-1:0] in;
  logic [CSZ-1:0] len;
  logic           clr;
  logic [OSZ-1:0] out;
  logic           valid;
  logic           sat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  usat_integ dut (
    .clk   (clk),
    .reset (reset),
    .ena   (ena),
    .in    (in),
    .len   (len),
`ifdef SAT_INTEG_CLR_EN
    .clr   (clr),
`endif
    .out   (out),
    .valid (valid),
    .sat   (sat)
  );

  // Standalone adder instance for a few direct checks.
  logic [OSZ-1:0] add_a;
  logic [ISZ-1:0] add_b;
  logic [OSZ-1:0] add_sum;
  logic           add_ovf;

  usat_add u_add_ref (
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  typedef struct {
    logic           ena;
    logic [ISZ-1:0] in;
    logic [CSZ-1:0] len;
    logic           valid;
    logic [OSZ-1:0] out;
    logic           sat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void addv(input logic e, input int i, input int l,
                               input logic v, input int o, input logic s);
    vec_t t;
    t.ena = e; t.in = ISZ'(i); t.len = CSZ'(l);
    t.valid = v; t.out = OSZ'(o); t.sat = s;
    vecs.push_back(t);
  endfunction

  // Drive one cycle of inputs at the falling edge, then sample just after
  // the next rising edge.
  task automatic step(input logic e, input int i, input int l, input logic c);
    @(negedge clk);
    ena = e; in = ISZ'(i); len = CSZ'(l); clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic v, input int o, input logic s);
    check({name, ".valid"}, {31'd0, valid}, {31'd0, v});
    check({name, ".out"},   {16'd0, out},   32'(o));
    check({name, ".sat"},   {31'd0, sat},   {31'd0, s});
  endtask

  initial begin
    reset = 1'b1; ena = 1'b0; in = '0; len = '0; clr = 1'b0;
    add_a = '0; add_b = '0;

    // Adder corner cases.
    add_a = 16'd100; add_b = 12'd200; #1;
    check("add.plain.sum", 32'(add_sum), 32'd300);
    check("add.plain.ovf", 32'(add_ovf), 32'd0);
    add_a = 16'd65000; add_b = 12'd535; #1;
    check("add.edge.sum", 32'(add_sum), 32'd65535);
    check("add.edge.ovf", 32'(add_ovf), 32'd0);
    add_a = OSZ_ONES; add_b = 12'd1; #1;
    check("add.ovf.sum", 32'(add_sum), 32'd65535);
    check("add.ovf.ovf", 32'(add_ovf), 32'd1);

    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b0, 0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // len=3, four samples summing to 1000; valid lasts one cycle.
    addv(1, 100, 3, 0, 0, 0);
    addv(1, 200, 3, 0, 0, 0);
    addv(1, 300, 3, 0, 0, 0);
    addv(1, 400, 3, 1, 1000, 0);
    addv(0, 0,   3, 0, 1000, 0);
    // len=0: every sample dumps, out = in delayed one cycle.
    addv(1, 1, 0, 1, 1, 0);
    addv(1, 2, 0, 1, 2, 0);
    addv(1, 3, 0, 1, 3, 0);
    addv(0, 0, 0, 0, 3, 0);
    // len=1 with a 5-cycle gap between samples.
    addv(1, 7, 1, 0, 3, 0);
    for (int k = 0; k < 5; k++) addv(0, 0, 1, 0, 3, 0);
    addv(1, 9, 1, 1, 16, 0);
    // len changes mid-block: block stays 4 samples, next block uses 2.
    addv(1, 5, 3, 0, 16, 0);
    addv(1, 5, 3, 0, 16, 0);
    addv(1, 5, 1, 0, 16, 0);
    addv(1, 5, 1, 1, 20, 0);
    addv(1, 6, 1, 0, 20, 0);
    addv(1, 6, 1, 1, 12, 0);
    addv(0, 0, 1, 0, 12, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].ena, int'(vecs[k].in), int'(vecs[k].len), 1'b0);
      check_out($sformatf("vec%0d", k), vecs[k].valid, int'(vecs[k].out), vecs[k].sat);
    end

    // 32 full-scale samples overflow at the 17th and clamp.
    for (int k = 0; k < 32; k++) begin
      step(1'b1, 4095, 31, 1'b0);
      if (k < 31) check_out($sformatf("satblk%0d", k), 1'b0, 12, 1'b0);
      else        check_out("satblk.dump", 1'b1, 65535, 1'b1);
    end
    // Next block of 32 ones starts clean.
    for (int k = 0; k < 32; k++) begin
      step(1'b1, 1, 31, 1'b0);
      if (k < 31) check_out($sformatf("oneblk%0d", k), 1'b0, 65535, 1'b1);
      else        check_out("oneblk.dump", 1'b1, 32, 1'b0);
    end

    // Asynchronous reset mid-block discards the partial sum.
    step(1'b1, 10, 3, 1'b0);
    step(1'b1, 10, 3, 1'b0);
    check_out("prereset", 1'b0, 32, 1'b0);
    ena = 1'b0;
    #2 reset = 1'b1;
    #1 check_out("midreset", 1'b0, 0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 10, 3, 1'b0);
      if (k < 3) check_out($sformatf("postreset%0d", k), 1'b0, 0, 1'b0);
      else       check_out("postreset.dump", 1'b1, 40, 1'b0);
    end
    step(1'b0, 0, 3, 1'b0);
    check_out("postreset.hold", 1'b0, 40, 1'b0);

`ifdef SAT_INTEG_CLR_EN
    // clr on the final sample aborts the block; out holds.
    step(1'b1, 10, 3, 1'b0);
    step(1'b1, 10, 3, 1'b0);
    step(1'b1, 10, 3, 1'b0);
    step(1'b1, 10, 3, 1'b1);
    check_out("clr.abort", 1'b0, 40, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 2, 3, 1'b0);
      if (k < 3) check_out($sformatf("postclr%0d", k), 1'b0, 40, 1'b0);
      else       check_out("postclr.dump", 1'b1, 8, 1'b0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
